// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD command sequencer:
// FSM state encoding, command identifiers and fixed command fields.
package sd_pkg;

  typedef enum logic [4:0] {
    ST_IDLE         = 5'd0,
    ST_WARM         = 5'd1,
    ST_ISSUE_CMD0   = 5'd2,
    ST_WAIT_CMD0    = 5'd3,
    ST_ISSUE_CMD8   = 5'd4,
    ST_WAIT_CMD8    = 5'd5,
    ST_ISSUE_CMD55  = 5'd6,
    ST_WAIT_CMD55   = 5'd7,
    ST_ISSUE_ACMD41 = 5'd8,
    ST_WAIT_ACMD41  = 5'd9,
    ST_ISSUE_CMD16  = 5'd10,
    ST_WAIT_CMD16   = 5'd11,
    ST_READY        = 5'd12,
    ST_ISSUE_CMD17  = 5'd13,
    ST_WAIT_CMD17   = 5'd14,
    ST_ERROR        = 5'd15
  } state_t;

  typedef enum logic [2:0] {
    CID_NONE, CID_CMD0, CID_CMD8, CID_CMD55, CID_ACMD41, CID_CMD16, CID_CMD17
  } cmd_id_t;

  typedef struct packed {
    logic [7:0]  num;
    logic [31:0] arg;
    logic [7:0]  crc;
  } cmd_fields_t;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;

  localparam logic [7:0]  CMD0_NUM   = 8'h40;
  localparam logic [31:0] CMD0_ARG   = 32'h0000_0000;
  localparam logic [7:0]  CMD0_CRC   = 8'h95;
  localparam logic [7:0]  CMD8_NUM   = 8'h48;
  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [7:0]  CMD8_CRC   = 8'h87;
  localparam logic [11:0] CMD8_ECHO  = 12'h1AA;
  localparam logic [7:0]  CMD55_NUM  = 8'h77;
  localparam logic [31:0] CMD55_ARG  = 32'h0000_0000;
  localparam logic [7:0]  CMD55_CRC  = 8'h65;
  localparam logic [7:0]  ACMD41_NUM = 8'h69;
  localparam logic [31:0] ACMD41_ARG = 32'h4000_0000;
  localparam logic [7:0]  ACMD41_CRC = 8'h77;
  localparam logic [7:0]  CMD16_NUM  = 8'h50;
  localparam logic [31:0] CMD16_ARG  = 32'h0000_0200;
  localparam logic [7:0]  CMD16_CRC  = 8'hFF;
  localparam logic [7:0]  CMD17_NUM  = 8'h51;
  localparam logic [7:0]  CMD17_CRC  = 8'hFF;

  function automatic cmd_id_t state_cmd_id(state_t s);
    case (s)
      ST_ISSUE_CMD0,   ST_WAIT_CMD0:   return CID_CMD0;
      ST_ISSUE_CMD8,   ST_WAIT_CMD8:   return CID_CMD8;
      ST_ISSUE_CMD55,  ST_WAIT_CMD55:  return CID_CMD55;
      ST_ISSUE_ACMD41, ST_WAIT_ACMD41: return CID_ACMD41;
      ST_ISSUE_CMD16,  ST_WAIT_CMD16:  return CID_CMD16;
      ST_ISSUE_CMD17,  ST_WAIT_CMD17:  return CID_CMD17;
      default:                         return CID_NONE;
    endcase
  endfunction

  function automatic logic is_issue(state_t s);
    return (s == ST_ISSUE_CMD0) || (s == ST_ISSUE_CMD8) || (s == ST_ISSUE_CMD55) ||
           (s == ST_ISSUE_ACMD41) || (s == ST_ISSUE_CMD16) || (s == ST_ISSUE_CMD17);
  endfunction

  function automatic logic is_wait(state_t s);
    return (s == ST_WAIT_CMD0) || (s == ST_WAIT_CMD8) || (s == ST_WAIT_CMD55) ||
           (s == ST_WAIT_ACMD41) || (s == ST_WAIT_CMD16) || (s == ST_WAIT_CMD17);
  endfunction

  // CMD17 is the only command whose argument is not a constant.
  function automatic cmd_fields_t cmd_fields(cmd_id_t id, logic [31:0] addr);
    case (id)
      CID_CMD0:   return '{CMD0_NUM,   CMD0_ARG,   CMD0_CRC};
      CID_CMD8:   return '{CMD8_NUM,   CMD8_ARG,   CMD8_CRC};
      CID_CMD55:  return '{CMD55_NUM,  CMD55_ARG,  CMD55_CRC};
      CID_ACMD41: return '{ACMD41_NUM, ACMD41_ARG, ACMD41_CRC};
      CID_CMD16:  return '{CMD16_NUM,  CMD16_ARG,  CMD16_CRC};
      CID_CMD17:  return '{CMD17_NUM,  addr,       CMD17_CRC};
      default:    return '{8'h00,      32'h0,      8'hFF};
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the single-command
// engine sd_cmd (slave).
interface sd_cmd_sequencer_if;
  logic [7:0]  cmd_number;
  logic [31:0] cmd_args;
  logic [7:0]  cmd_crc;
  logic        cmd_start;
  logic        cmd_done;
  logic [7:0]  cmd_flags;
  logic [31:0] cmd_data;

  modport master (
    output cmd_number, cmd_args, cmd_crc, cmd_start,
    input  cmd_done, cmd_flags, cmd_data
  );

  modport slave (
    input  cmd_number, cmd_args, cmd_crc, cmd_start,
    output cmd_done, cmd_flags, cmd_data
  );
endinterface

// File: rtl/sd_resp_check.sv
// Combinational R1/R7 response classifier: ok, retry (ACMD41 still idle)
// or fail, depending on which command the response belongs to.
module sd_resp_check
  import sd_pkg::*;
(
  input  cmd_id_t     i_cmd_id,
  input  logic [7:0]  i_flags,
  input  logic [11:0] i_echo,
  output logic        o_ok,
  output logic        o_retry,
  output logic        o_fail
);

  always_comb begin
    o_ok    = 1'b0;
    o_retry = 1'b0;
    case (i_cmd_id)
      CID_CMD0:   o_ok = (i_flags == R1_IDLE);
      CID_CMD8:   o_ok = (i_flags == R1_IDLE) && (i_echo == CMD8_ECHO);
      CID_CMD55:  o_ok = (i_flags == R1_IDLE) || (i_flags == R1_READY);
      CID_ACMD41: begin
        o_ok    = (i_flags == R1_READY);
        o_retry = (i_flags == R1_IDLE);
      end
      CID_CMD16:  o_ok = (i_flags == R1_READY);
      CID_CMD17:  o_ok = (i_flags == R1_READY);
      default:    o_ok = 1'b0;
    endcase
    o_fail = !o_ok && !o_retry;
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD card SPI-mode init/read sequencer driving sd_cmd. Optional per-command
// watchdog enabled by defining SD_SEQ_TIMEOUT_EN.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES  = 80,
  parameter int unsigned INIT_RETRIES   = 255,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init_start,
  input  logic                read_start,
  input  logic [31:0]         read_addr,
  output logic                init_done,
  output logic                init_error,
  output logic                read_done,
  output logic                read_error,
  output logic [7:0]          read_flags,
  output logic [31:0]         read_data,
  output logic                busy,
  output logic [4:0]          cur_state,
  sd_cmd_sequencer_if.master  cmd
);

  if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 65536 || INIT_RETRIES < 1 ||
      INIT_RETRIES > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("sd_cmd_sequencer: parameter out of range");
  end

  state_t      r_state, w_state_nxt;
  logic [15:0] r_warm;
  logic [7:0]  r_retry;
  logic [31:0] r_addr;
  logic [7:0]  r_cmd_number, r_cmd_crc, r_read_flags;
  logic [31:0] r_cmd_args, r_read_data;
  logic        r_cmd_start, r_init_done, r_init_error, r_read_done, r_read_error, r_busy;

  cmd_id_t     w_cid;
  cmd_fields_t w_fields;
  logic        w_ok, w_retry, w_fail, w_retry_last, w_warm_entry, w_cmd17_fin;
  logic        w_wdog_tc;

  assign w_cid        = state_cmd_id(r_state);
  assign w_fields     = cmd_fields(w_cid, r_addr);
  assign w_retry_last = (r_retry + 8'd1) == 8'(INIT_RETRIES);
  assign w_warm_entry = (w_state_nxt == ST_WARM) && (r_state != ST_WARM);
  assign w_cmd17_fin  = (r_state == ST_WAIT_CMD17) && cmd.cmd_done;

  sd_resp_check u_resp_check (
    .i_cmd_id (w_cid),
    .i_flags  (cmd.cmd_flags),
    .i_echo   (cmd.cmd_data[11:0]),
    .o_ok     (w_ok),
    .o_retry  (w_retry),
    .o_fail   (w_fail)
  );

`ifdef SD_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Loaded in ISSUE so the terminal count lands TIMEOUT_CYCLES after it.
  always_ff @(posedge clk) begin
    if (reset) r_wdog <= '0;
    else if (is_issue(r_state)) r_wdog <= 32'(TIMEOUT_CYCLES - 1);
    else if (is_wait(r_state) && r_wdog != '0) r_wdog <= r_wdog - 32'd1;
  end

  assign w_wdog_tc = is_wait(r_state) && (r_wdog == 32'd1) && !cmd.cmd_done;
`else
  assign w_wdog_tc = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:         if (init_start) w_state_nxt = ST_WARM;
      ST_WARM:         if (r_warm == '0) w_state_nxt = ST_ISSUE_CMD0;
      ST_ISSUE_CMD0:   w_state_nxt = ST_WAIT_CMD0;
      ST_WAIT_CMD0:    if (cmd.cmd_done) w_state_nxt = w_ok ? ST_ISSUE_CMD8 : ST_ERROR;
      ST_ISSUE_CMD8:   w_state_nxt = ST_WAIT_CMD8;
      ST_WAIT_CMD8:    if (cmd.cmd_done) w_state_nxt = w_ok ? ST_ISSUE_CMD55 : ST_ERROR;
      ST_ISSUE_CMD55:  w_state_nxt = ST_WAIT_CMD55;
      ST_WAIT_CMD55:   if (cmd.cmd_done) w_state_nxt = w_ok ? ST_ISSUE_ACMD41 : ST_ERROR;
      ST_ISSUE_ACMD41: w_state_nxt = ST_WAIT_ACMD41;
      ST_WAIT_ACMD41: begin
        if (cmd.cmd_done) begin
          if (w_ok)                       w_state_nxt = ST_ISSUE_CMD16;
          else if (w_retry && !w_retry_last) w_state_nxt = ST_ISSUE_CMD55;
          else                            w_state_nxt = ST_ERROR;
        end
      end
      ST_ISSUE_CMD16:  w_state_nxt = ST_WAIT_CMD16;
      ST_WAIT_CMD16:   if (cmd.cmd_done) w_state_nxt = w_ok ? ST_READY : ST_ERROR;
      ST_READY: begin
        if (init_start)      w_state_nxt = ST_WARM;
        else if (read_start) w_state_nxt = ST_ISSUE_CMD17;
      end
      ST_ISSUE_CMD17:  w_state_nxt = ST_WAIT_CMD17;
      ST_WAIT_CMD17:   if (cmd.cmd_done) w_state_nxt = ST_READY;
      ST_ERROR:        if (init_start) w_state_nxt = ST_WARM;
      default:         w_state_nxt = ST_IDLE;
    endcase
    if (w_wdog_tc) w_state_nxt = (r_state == ST_WAIT_CMD17) ? ST_READY : ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_warm       <= '0;
      r_retry      <= '0;
      r_addr       <= '0;
      r_cmd_start  <= 1'b0;
      r_cmd_number <= '0;
      r_cmd_args   <= '0;
      r_cmd_crc    <= 8'hFF;
      r_init_done  <= 1'b0;
      r_init_error <= 1'b0;
      r_read_done  <= 1'b0;
      r_read_error <= 1'b0;
      r_read_flags <= '0;
      r_read_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_warm_entry) begin
        r_warm  <= 16'(WARMUP_CYCLES - 1);
        r_retry <= '0;
      end else begin
        if (r_state == ST_WARM && r_warm != '0) r_warm <= r_warm - 16'd1;
        if (r_state == ST_WAIT_ACMD41 && cmd.cmd_done && w_retry) r_retry <= r_retry + 8'd1;
      end
      if (r_state == ST_READY && w_state_nxt == ST_ISSUE_CMD17) r_addr <= read_addr;
      // Fields are captured with the start pulse and held through the wait.
      r_cmd_start <= is_issue(r_state);
      if (is_issue(r_state)) begin
        r_cmd_number <= w_fields.num;
        r_cmd_args   <= w_fields.arg;
        r_cmd_crc    <= w_fields.crc;
      end
      r_init_done  <= (w_state_nxt == ST_READY);
      r_init_error <= (w_state_nxt == ST_ERROR);
      r_busy       <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_READY) ||
                        (w_state_nxt == ST_ERROR));
      r_read_done  <= w_cmd17_fin && w_ok;
      r_read_error <= w_cmd17_fin && w_fail;
      if (w_cmd17_fin) begin
        r_read_flags <= cmd.cmd_flags;
        r_read_data  <= cmd.cmd_data;
      end
      if (w_wdog_tc && r_state == ST_WAIT_CMD17) begin
        r_read_error <= 1'b1;
        r_read_flags <= 8'hFF;
      end
    end
  end

  assign cmd.cmd_start  = r_cmd_start;
  assign cmd.cmd_number = r_cmd_number;
  assign cmd.cmd_args   = r_cmd_args;
  assign cmd.cmd_crc    = r_cmd_crc;
  assign init_done      = r_init_done;
  assign init_error     = r_init_error;
  assign read_done      = r_read_done;
  assign read_error     = r_read_error;
  assign read_flags     = r_read_flags;
  assign read_data      = r_read_data;
  assign busy           = r_busy;
  assign cur_state      = r_state;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: init sequence, ACMD41 exhaustion,
// reads, reset mid-command and simultaneous requests.
module tb_sd_cmd_sequencer;

  localparam int unsigned W = 4;

  logic        clk = 1'b0;
  logic        reset, init_start, read_start;
  logic [31:0] read_addr;
  logic        init_done, init_error, read_done, read_error, busy;
  logic [7:0]  read_flags;
  logic [31:0] read_data;
  logic [4:0]  cur_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] log_q[$];

  always #5 clk = ~clk;

  sd_cmd_sequencer_if u_if ();

  sd_cmd_sequencer #(
    .WARMUP_CYCLES  (W),
    .INIT_RETRIES   (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .read_start (read_start),
    .read_addr  (read_addr),
    .init_done  (init_done),
    .init_error (init_error),
    .read_done  (read_done),
    .read_error (read_error),
    .read_flags (read_flags),
    .read_data  (read_data),
    .busy       (busy),
    .cur_state  (cur_state),
    .cmd        (u_if)
  );

  always @(posedge clk) if (u_if.cmd_start) log_q.push_back(u_if.cmd_number);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Counts negedges until cmd_start is seen; a missing start shows up as k=400.
  task automatic wait_start(input string tag, input int exp_k);
    int k;
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (u_if.cmd_start) break;
    end
    chk(tag, k, exp_k);
  endtask

  task automatic respond(input string tag, input logic [7:0] num, input logic [31:0] arg,
                         input logic [7:0] crc, input logic [7:0] fl, input logic [31:0] dat);
    chk({tag, "_num"}, u_if.cmd_number, num);
    chk({tag, "_arg"}, u_if.cmd_args, arg);
    chk({tag, "_crc"}, u_if.cmd_crc, crc);
    @(negedge clk);
    u_if.cmd_done  = 1'b1;
    u_if.cmd_flags = fl;
    u_if.cmd_data  = dat;
    @(negedge clk);
    u_if.cmd_done  = 1'b0;
  endtask

  task automatic kick_init();
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_init[7];
    int idx;
    int n41;
    int n16;
    exp_init = '{8'h40, 8'h48, 8'h77, 8'h69, 8'h77, 8'h69, 8'h50};

    reset = 1'b1; init_start = 1'b0; read_start = 1'b0; read_addr = '0;
    u_if.cmd_done = 1'b0; u_if.cmd_flags = '0; u_if.cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", cur_state, 5'd0);
    chk("rst_crc", u_if.cmd_crc, 8'hFF);
    chk("rst_start", u_if.cmd_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Normal init: one ACMD41 retry before the card reports ready.
    kick_init();
    chk("warm_state", cur_state, 5'd1);
    chk("warm_busy", busy, 1'b1);
    wait_start("lat_init", W + 1);
    respond("cmd0", 8'h40, 32'h0, 8'h95, 8'h01, 32'h0);
    wait_start("gap_cmd8", 1);
    respond("cmd8", 8'h48, 32'h1AA, 8'h87, 8'h01, 32'h0000_01AA);
    wait_start("gap_cmd55a", 1);
    respond("cmd55a", 8'h77, 32'h0, 8'h65, 8'h01, 32'h0);
    wait_start("gap_acmd41a", 1);
    respond("acmd41a", 8'h69, 32'h4000_0000, 8'h77, 8'h01, 32'h0);
    wait_start("gap_cmd55b", 1);
    respond("cmd55b", 8'h77, 32'h0, 8'h65, 8'h01, 32'h0);
    wait_start("gap_acmd41b", 1);
    respond("acmd41b", 8'h69, 32'h4000_0000, 8'h77, 8'h00, 32'h0);
    wait_start("gap_cmd16", 1);
    respond("cmd16", 8'h50, 32'h200, 8'hFF, 8'h00, 32'h0);
    chk("init_done", init_done, 1'b1);
    chk("ready_state", cur_state, 5'd12);
    chk("ready_busy", busy, 1'b0);
    chk("log_len", log_q.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("order%0d", i), log_q[i], exp_init[i]);

    // Successful read.
    read_start = 1'b1; read_addr = 32'h0000_0207;
    @(negedge clk);
    read_start = 1'b0; read_addr = 32'hFFFF_FFFF;
    wait_start("lat_read", 1);
    respond("rd1", 8'h51, 32'h0000_0207, 8'hFF, 8'h00, 32'hDEAD_BEEF);
    chk("rd1_done", read_done, 1'b1);
    chk("rd1_err", read_error, 1'b0);
    chk("rd1_data", read_data, 32'hDEAD_BEEF);
    chk("rd1_flags", read_flags, 8'h00);
    @(negedge clk);
    chk("rd1_pulse", read_done, 1'b0);

    // Failed read.
    read_start = 1'b1; read_addr = 32'h0000_0300;
    @(negedge clk);
    read_start = 1'b0;
    wait_start("lat_read2", 1);
    respond("rd2", 8'h51, 32'h0000_0300, 8'hFF, 8'h05, 32'h1234_5678);
    chk("rd2_err", read_error, 1'b1);
    chk("rd2_done", read_done, 1'b0);
    chk("rd2_flags", read_flags, 8'h05);
    chk("rd2_data", read_data, 32'h1234_5678);
    chk("rd2_initdone", init_done, 1'b1);
    @(negedge clk);
    chk("rd2_pulse", read_error, 1'b0);

    // init_start beats read_start, then reset lands in WAIT(CMD8).
    idx = log_q.size();
    init_start = 1'b1; read_start = 1'b1; read_addr = 32'h0000_0999;
    @(negedge clk);
    init_start = 1'b0; read_start = 1'b0;
    chk("simul_state", cur_state, 5'd1);
    wait_start("simul_lat", W + 1);
    respond("s_cmd0", 8'h40, 32'h0, 8'h95, 8'h01, 32'h0);
    wait_start("s_gap", 1);
    chk("s_cmd8_num", u_if.cmd_number, 8'h48);
    @(negedge clk);
    chk("s_wait8", cur_state, 5'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_state", cur_state, 5'd0);
    chk("mr_start", u_if.cmd_start, 1'b0);
    chk("mr_num", u_if.cmd_number, 8'h00);
    chk("mr_args", u_if.cmd_args, 32'h0);
    chk("mr_crc", u_if.cmd_crc, 8'hFF);
    chk("mr_busy", busy, 1'b0);
    chk("mr_initdone", init_done, 1'b0);
    chk("mr_flags", read_flags, 8'h00);
    chk("mr_data", read_data, 32'h0);
    repeat (6) @(negedge clk);
    chk("mr_idle", cur_state, 5'd0);
    chk("s_log_len", log_q.size(), idx + 2);
    chk("s_log0", log_q[idx], 8'h40);
    chk("s_log1", log_q[idx + 1], 8'h48);

    // ACMD41 never leaves idle: give up after three attempts.
    idx = log_q.size();
    kick_init();
    wait_start("x_lat", W + 1);
    respond("x_cmd0", 8'h40, 32'h0, 8'h95, 8'h01, 32'h0);
    wait_start("x_gap8", 1);
    respond("x_cmd8", 8'h48, 32'h1AA, 8'h87, 8'h01, 32'h0000_01AA);
    for (int i = 0; i < 3; i++) begin
      wait_start($sformatf("x_gap55_%0d", i), 1);
      respond($sformatf("x_cmd55_%0d", i), 8'h77, 32'h0, 8'h65, 8'h01, 32'h0);
      wait_start($sformatf("x_gap41_%0d", i), 1);
      respond($sformatf("x_acmd41_%0d", i), 8'h69, 32'h4000_0000, 8'h77, 8'h01, 32'h0);
    end
    chk("x_error", init_error, 1'b1);
    chk("x_state", cur_state, 5'd15);
    chk("x_busy", busy, 1'b0);
    chk("x_initdone", init_done, 1'b0);
    repeat (10) @(negedge clk);
    chk("x_hold", cur_state, 5'd15);
    n41 = 0; n16 = 0;
    for (int i = idx; i < log_q.size(); i++) begin
      if (log_q[i] == 8'h69) n41++;
      if (log_q[i] == 8'h50) n16++;
    end
    chk("x_n41", n41, 3);
    chk("x_n16", n16, 0);
    chk("x_log_len", log_q.size(), idx + 8);

    kick_init();
    chk("err_exit", cur_state, 5'd1);

`ifdef SD_SEQ_TIMEOUT_EN
    begin
      int k;
      wait_start("to_lat", W + 1);
      k = 1;
      while (k < 100) begin
        @(negedge clk);
        k++;
        if (cur_state == 5'd15) break;
      end
      chk("to_cycles", k, 16);
      chk("to_error", init_error, 1'b1);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
